mips_multicycle_ctrl: RTL
=========================

MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, the maximum number of wait cycles on a memory access before an error is raised (range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port Opcode, input, 6 bits: Instr[31:26], taken from the instruction register.
REQ-005 SHALL have port Funct, input, 6 bits: Instr[5:0].
REQ-006 SHALL have port zero, input, 1 bit: the ALU zero flag.
REQ-007 SHALL have port mem_ready, input, 1 bit: the memory's acknowledge of the current access.
REQ-008 SHALL have port mem_req, output, 1 bit: a memory access is in progress.
REQ-009 SHALL have outputs IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite and ALUSrcA, each 1 bit: the multicycle datapath selects and enables.
REQ-010 SHALL have outputs ALUSrcB and PCSrc, each 2 bits: the ALU B-operand select and the next-PC select.
REQ-011 SHALL have output ALU_Control, 3 bits: the ALU operation.
REQ-012 SHALL have output PCEn, 1 bit: the PC register load enable.
REQ-013 SHALL have output illegal, 1 bit: a one-cycle pulse on an unsupported opcode or funct.
REQ-014 SHALL have output mem_err, 1 bit: a sticky memory-timeout flag.

Function
REQ-015 SHALL implement states IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP and HALT.
REQ-016 SHALL take these transitions:
- IDLE->FETCH unconditionally.
- FETCH->DECODE on mem_ready.
- DECODE by opcode:
  - lw 100011 / sw 101011 -> MEMADR.
  - R-type 000000 -> EXEC.
  - beq 000100 -> BRANCH.
  - addi 001000 -> ADDIEX.
  - j 000010 -> JUMP.
  - any other opcode -> FETCH, with illegal pulsed.
- MEMADR->MEMRD for lw, MEMADR->MEMWR for sw.
- MEMRD->MEMWB on mem_ready; MEMWR->FETCH on mem_ready.
- MEMWB, ALUWB, ADDIWB, BRANCH and JUMP -> FETCH.
- EXEC->ALUWB; ADDIEX->ADDIWB.
REQ-017 SHALL hold FETCH, MEMRD and MEMWR while mem_ready=0, with mem_req=1 throughout.
REQ-018 SHALL drive these Moore outputs (every output not listed is 0):
- FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_Control=010, PCSrc=00.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALU_Control=010.
- MEMADR and ADDIEX: ALUSrcA=1, ALUSrcB=10, ALU_Control=010.
- MEMRD: IorD=1.
- MEMWR: IorD=1, MemWrite=1.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALU_Control from Funct.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALU_Control=110, PCSrc=01.
- JUMP: PCSrc=10.
REQ-019 SHALL assert IRWrite, and PCEn, in FETCH only in the cycle where mem_ready=1.
REQ-020 SHALL assert PCEn in BRANCH iff zero=1, and in JUMP unconditionally.
REQ-021 SHALL map Funct to ALU_Control as follows; any other Funct drives 010, pulses illegal in EXEC, and suppresses RegWrite in the following ALUWB:
- 100000 -> 010
- 100010 -> 110
- 100100 -> 000
- 100101 -> 001
- 101010 -> 111
REQ-022 SHALL count consecutive cycles with mem_req=1 and mem_ready=0 using an 8-bit counter that clears on mem_ready or on leaving the state.
REQ-023 SHALL, when the wait counter reaches MEM_TIMEOUT, set mem_err, enter HALT, and keep all outputs except mem_err at 0 until reset.
REQ-024 SHALL give mem_ready priority over the timeout when both occur in the same cycle.

Reset
REQ-025 SHALL, while rst=0, force the state to IDLE, clear the wait counter and mem_err, and drive every output to 0.
REQ-026 SHALL abort any in-progress memory access when reset is asserted mid-operation, with no PCEn, RegWrite or MemWrite afterwards.

Configuration
REQ-027 SHALL support bne (opcode 000101) when MIPS_CTRL_BNE_EN is defined:
- DECODE goes to BRANCH.
- In BRANCH, PCEn = zero XOR is_bne, where is_bne is latched in DECODE.
REQ-028 SHALL, when MIPS_CTRL_BNE_EN is undefined, treat opcode 000101 as illegal.

Structure
REQ-029 SHALL place the state enum, the opcode and funct constants and the ALU_Control codes in package mips_ctrl_pkg.
REQ-030 SHALL implement the Funct->ALU_Control decode as combinational sub-module alu_decoder.

Verification
REQ-031 SHALL cover these directed scenarios:
- lw 0x8C... with mem_ready high every cycle -> visits FETCH, DECODE, MEMADR, MEMRD, MEMWB; 5 cycles; RegWrite=1 and MemtoReg=1 in the 5th.
- R-type Funct=101010 -> ALU_Control=111 in EXEC; ALUWB has RegWrite=1, RegDst=1; 4 cycles.
- beq with zero=1, then with zero=0 -> PCEn=1 in BRANCH, then PCEn=0.
- FETCH with mem_ready held low for 3 cycles -> FETCH held, IRWrite=0 until the 4th cycle; mem_ready never arriving -> mem_err=1 after exactly 15 wait cycles, then HALT.
- Opcode 111111 -> illegal pulses for 1 cycle and the next state is FETCH; opcode 000101 follows REQ-027 or REQ-028 according to the macro.
- rst driven low in MEMWR -> all outputs 0 asynchronously; IDLE then FETCH after release.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit:
// FSM states, opcode/funct constants and ALU operation codes.
package mips_ctrl_pkg;

    localparam int unsigned OP_W   = 6;
    localparam int unsigned ALU_W  = 3;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, HALT
    } state_e;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [OP_W-1:0] FN_ADD   = 6'b100000;
    localparam logic [OP_W-1:0] FN_SUB   = 6'b100010;
    localparam logic [OP_W-1:0] FN_AND   = 6'b100100;
    localparam logic [OP_W-1:0] FN_OR    = 6'b100101;
    localparam logic [OP_W-1:0] FN_SLT   = 6'b101010;

    localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/alu_decoder.sv
// Combinational Funct -> ALU operation decode; flags unsupported Funct codes.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [OP_W-1:0]  i_funct,
    output logic [ALU_W-1:0] o_alu_ctrl_c,
    output logic             o_funct_ok_c
);

    always_comb begin
        o_alu_ctrl_c = ALU_ADD;
        o_funct_ok_c = 1'b1;
        case (i_funct)
            FN_ADD:  o_alu_ctrl_c = ALU_ADD;
            FN_SUB:  o_alu_ctrl_c = ALU_SUB;
            FN_AND:  o_alu_ctrl_c = ALU_AND;
            FN_OR:   o_alu_ctrl_c = ALU_OR;
            FN_SLT:  o_alu_ctrl_c = ALU_SLT;
            default: o_funct_ok_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM with memory wait handling and timeout halt.
// Define MIPS_CTRL_BNE_EN to add bne support (otherwise opcode 000101 is illegal).
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OP_W-1:0]  Opcode,
    input  logic [OP_W-1:0]  Funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             IorD,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSrc,
    output logic [ALU_W-1:0] ALU_Control,
    output logic             PCEn,
    output logic             illegal,
    output logic             mem_err
);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic               r_mem_err;
    logic               r_funct_bad;
    logic               w_mem_wait;
    logic               w_timeout;
    logic               w_branch_take;
    logic [ALU_W-1:0]   w_alu_ctrl;
    logic               w_funct_ok;
`ifdef MIPS_CTRL_BNE_EN
    logic               r_is_bne;
`endif

    alu_decoder u_alu_decoder (
        .i_funct      (Funct),
        .o_alu_ctrl_c (w_alu_ctrl),
        .o_funct_ok_c (w_funct_ok)
    );

`ifdef MIPS_CTRL_BNE_EN
    assign w_branch_take = zero ^ r_is_bne;
`else
    assign w_branch_take = zero;
`endif

    assign mem_err = r_mem_err;

    // State, wait counter and sticky/latched flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_wait_cnt  <= '0;
            r_mem_err   <= 1'b0;
            r_funct_bad <= 1'b0;
`ifdef MIPS_CTRL_BNE_EN
            r_is_bne    <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_mem_wait ? r_wait_cnt + CNT_W'(1) : '0;
            r_mem_err  <= r_mem_err | w_timeout;
            if (r_state == EXEC) r_funct_bad <= ~w_funct_ok;
`ifdef MIPS_CTRL_BNE_EN
            if (r_state == DECODE) r_is_bne <= (Opcode == OP_BNE);
`endif
        end
    end

    // Next state and Moore/Mealy control outputs
    always_comb begin
        w_state_nxt = r_state;
        mem_req     = 1'b0;
        IorD        = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSrc       = 2'b00;
        ALU_Control = ALU_AND;
        PCEn        = 1'b0;
        illegal     = 1'b0;
        w_mem_wait  = 1'b0;
        w_timeout   = 1'b0;

        case (r_state)
            IDLE: w_state_nxt = FETCH;
            FETCH: begin
                mem_req     = 1'b1;
                ALUSrcB     = 2'b01;
                ALU_Control = ALU_ADD;
                if (mem_ready) begin
                    IRWrite     = 1'b1;
                    PCEn        = 1'b1;
                    w_state_nxt = DECODE;
                end
            end
            DECODE: begin
                ALUSrcB     = 2'b11;
                ALU_Control = ALU_ADD;
                case (Opcode)
                    OP_LW, OP_SW: w_state_nxt = MEMADR;
                    OP_RTYPE:     w_state_nxt = EXEC;
                    OP_BEQ:       w_state_nxt = BRANCH;
`ifdef MIPS_CTRL_BNE_EN
                    OP_BNE:       w_state_nxt = BRANCH;
`endif
                    OP_ADDI:      w_state_nxt = ADDIEX;
                    OP_J:         w_state_nxt = JUMP;
                    default: begin
                        illegal     = 1'b1;
                        w_state_nxt = FETCH;
                    end
                endcase
            end
            MEMADR, ADDIEX: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = 2'b10;
                ALU_Control = ALU_ADD;
                if (r_state == ADDIEX) w_state_nxt = ADDIWB;
                else                   w_state_nxt = (Opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) w_state_nxt = MEMWB;
            end
            MEMWR: begin
                mem_req  = 1'b1;
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) w_state_nxt = FETCH;
            end
            MEMWB: begin
                MemtoReg    = 1'b1;
                RegWrite    = 1'b1;
                w_state_nxt = FETCH;
            end
            EXEC: begin
                ALUSrcA     = 1'b1;
                ALU_Control = w_alu_ctrl;
                illegal     = ~w_funct_ok;
                w_state_nxt = ALUWB;
            end
            ALUWB: begin
                RegDst      = 1'b1;
                RegWrite    = ~r_funct_bad;
                w_state_nxt = FETCH;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALU_Control = ALU_SUB;
                PCSrc       = 2'b01;
                PCEn        = w_branch_take;
                w_state_nxt = FETCH;
            end
            ADDIWB: begin
                RegWrite    = 1'b1;
                w_state_nxt = FETCH;
            end
            JUMP: begin
                PCSrc       = 2'b10;
                PCEn        = 1'b1;
                w_state_nxt = FETCH;
            end
            HALT: w_state_nxt = HALT;
            default: w_state_nxt = IDLE;
        endcase

        // mem_ready wins over a timeout landing in the same cycle
        w_mem_wait = mem_req & ~mem_ready;
        w_timeout  = w_mem_wait && (r_wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
        if (w_timeout) w_state_nxt = HALT;
    end

endmodule
